ws_pe_sequencer: RTL and testbench

//   Upstream control stage for one weight-stationary PE. Accepts a job (weight + input count)
//   and an input stream over valid/ready, then drives the PE's ready/rw/weight/input pins:
//   one weight-load cycle, one compute cycle per accepted input, one output-capture cycle.

---
 rtl/ws_pe_sequencer.sv | 146 ++++++++++++++
 tb/tb_ws_pe_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_pe_sequencer.sv
// ws_pe_sequencer
//   Upstream control stage for one weight-stationary PE. The block accepts a job
//   (stationary weight and input count) and then an input stream. It drives the
//   PE pins in this order: one weight-load cycle, one compute cycle per accepted
//   input, and one output-capture cycle. o_done pulses once the PE output
//   register holds the job's partial sum.
//
// Ports
//   w_clk, w_rst_n            clock and asynchronous active-low reset
//   s_cfg_valid/ready         job handshake; s_cfg_weight and s_cfg_len are the job
//                             (s_cfg_len is clamped to K_MAX)
//   s_in_valid/ready/data     input-sample stream
//   pe_ready/rw/weight/input  registered PE pins (rw: 0 = load/output, 1 = compute)
//   o_busy                    high in every state except IDLE
//   o_done                    one-cycle pulse; the PE output is valid from this cycle
//   o_in_cnt                  number of inputs accepted in the current job
module ws_pe_sequencer #(
  parameter  int WIDTH = 16,
  parameter  int K_MAX = 256,
  localparam int CNT_W = $clog2(K_MAX + 1)
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             s_cfg_valid,
  output logic             s_cfg_ready,
  input  logic [WIDTH-1:0] s_cfg_weight,
  input  logic [CNT_W-1:0] s_cfg_len,
  input  logic             s_in_valid,
  output logic             s_in_ready,
  input  logic [WIDTH-1:0] s_in_data,
  output logic             pe_ready,
  output logic             pe_rw,
  output logic [WIDTH-1:0] pe_weight,
  output logic [WIDTH-1:0] pe_input,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_in_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   weight_q, weight_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pe_ready_q, pe_ready_d;
  logic               pe_rw_q, pe_rw_d;
  logic [WIDTH-1:0]   pe_weight_q, pe_weight_d;
  logic [WIDTH-1:0]   pe_input_q, pe_input_d;
  logic               done_q, done_d;

  // The ready signals depend on the state only. This keeps the valid inputs
  // off any combinational path to an output.
  assign s_cfg_ready = (state_q == S_IDLE);
  assign s_in_ready  = (state_q == S_STREAM);
  assign o_busy      = (state_q != S_IDLE);

  logic cfg_hs, in_hs;
  assign cfg_hs = s_cfg_valid && s_cfg_ready;
  assign in_hs  = s_in_valid  && s_in_ready;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    weight_d    = weight_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    // Idle default on the PE pins: the PE holds both scratch and output.
    pe_ready_d  = 1'b0;
    pe_rw_d     = 1'b1;
    pe_weight_d = pe_weight_q;
    pe_input_d  = pe_input_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_hs) begin
          weight_d = s_cfg_weight;
          len_d    = (s_cfg_len > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : s_cfg_len;
          cnt_d    = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        pe_ready_d  = 1'b1;
        pe_rw_d     = 1'b0;
        pe_weight_d = weight_q;
        state_d     = (len_q != '0) ? S_STREAM : S_DRAIN;
      end
      S_STREAM: begin
        // With no handshake, pe_ready stays low. The PE sees a bubble and holds.
        if (in_hs) begin
          pe_ready_d = 1'b1;
          pe_input_d = s_in_data;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Output capture is issued one cycle after the last compute, so the
        // final product is already in scratch.
        pe_rw_d = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      weight_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pe_ready_q  <= 1'b0;
      pe_rw_q     <= 1'b1;
      pe_weight_q <= '0;
      pe_input_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      weight_q    <= weight_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pe_ready_q  <= pe_ready_d;
      pe_rw_q     <= pe_rw_d;
      pe_weight_q <= pe_weight_d;
      pe_input_q  <= pe_input_d;
      done_q      <= done_d;
    end
  end

  assign pe_ready  = pe_ready_q;
  assign pe_rw     = pe_rw_q;
  assign pe_weight = pe_weight_q;
  assign pe_input  = pe_input_q;
  assign o_done    = done_q;
  assign o_in_cnt  = cnt_q;

endmodule

// File: tb/tb_ws_pe_sequencer.sv
// Testbench for ws_pe_sequencer (K_MAX=8). A behavioural PE is driven by the
// sequencer pins. Each job's expected result is queued when its cfg handshake
// occurs. A monitor pops one entry per o_done and checks the following:
//   - the PE output
//   - the input count
//   - the counts of load, compute and drain cycles
//   - the held weight
//   - the edge number of the o_done pulse
module tb_ws_pe_sequencer;
  localparam int W  = 16;
  localparam int KM = 8;
  localparam int CW = 4;

  logic          w_clk = 1'b0, w_rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [W-1:0]  cfg_w = '0;
  logic [CW-1:0] cfg_len = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  in_data = '0;
  logic          pe_ready, pe_rw, o_busy, o_done;
  logic [W-1:0]  pe_weight, pe_input;
  logic [CW-1:0] o_in_cnt;

  ws_pe_sequencer #(.WIDTH(W), .K_MAX(KM)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .s_cfg_valid(cfg_valid), .s_cfg_ready(cfg_ready), .s_cfg_weight(cfg_w), .s_cfg_len(cfg_len),
    .s_in_valid(in_valid), .s_in_ready(in_ready), .s_in_data(in_data),
    .pe_ready(pe_ready), .pe_rw(pe_rw), .pe_weight(pe_weight), .pe_input(pe_input),
    .o_busy(o_busy), .o_done(o_done), .o_in_cnt(o_in_cnt)
  );

  always #5 w_clk = ~w_clk;

  int cyc = 0;
  always @(posedge w_clk) cyc <= cyc + 1;

  // Behavioural weight-stationary PE with its own synchronous reset.
  logic pe_rst_n = 1'b0;
  int   pe_w = 0, scratch = 0, pe_out = 0;
  always @(posedge w_clk) begin
    if (!pe_rst_n) begin
      pe_w <= 0; scratch <= 0; pe_out <= 0;
    end else if (pe_ready && !pe_rw) pe_w <= int'(pe_weight);
    else if (pe_ready && pe_rw)     scratch <= scratch + pe_w * int'(pe_input);
    else if (!pe_ready && !pe_rw)   pe_out <= scratch;
  end

  int n_chk = 0, n_pass = 0;
  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  typedef struct {
    int w; int cnt; int loads; int comps; int drains; int out; int done_edge;
  } exp_t;
  exp_t sbq[$];

  function automatic void push(int w, int cnt, int comps, int out, int de);
    exp_t e;
    e.w = w; e.cnt = cnt; e.loads = 1; e.comps = comps; e.drains = 1;
    e.out = out; e.done_edge = de;
    sbq.push_back(e);
  endfunction

  // Monitor: counts PE pin cycles and checks one queued expectation per o_done.
  initial begin
    int nl = 0, nc = 0, nd = 0;
    exp_t e;
    forever begin
      @(negedge w_clk);
      if (!w_rst_n) begin
        nl = 0; nc = 0; nd = 0;
      end else begin
        if (pe_ready && !pe_rw) nl++;
        if (pe_ready && pe_rw)  nc++;
        if (!pe_ready && !pe_rw) nd++;
        if (o_done) begin
          if (sbq.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("done_pe_out",  pe_out, e.out);
            chk("done_in_cnt",  int'(o_in_cnt), e.cnt);
            chk("done_loads",   nl, e.loads);
            chk("done_computes", nc, e.comps);
            chk("done_drains",  nd, e.drains);
            chk("done_weight",  int'(pe_weight), e.w);
            chk("done_edge",    cyc, e.done_edge);
          end
          nl = 0; nc = 0; nd = 0;
        end
      end
    end
  end

  // Called at a negedge. Returns at the negedge after the handshake edge.
  task automatic send_cfg(input int w, input int len, output int hs);
    int t = 0;
    cfg_valid = 1'b1; cfg_w = W'(w); cfg_len = CW'(len); hs = -1;
    while (hs < 0 && t < 200) begin
      if (cfg_ready) hs = cyc + 1;
      @(negedge w_clk); t++;
    end
    cfg_valid = 1'b0;
    if (hs < 0) chk("cfg_timeout", 1, 0);
  endtask

  task automatic send_in(input int d, input int gap, input int exp_cnt);
    int t = 0;
    bit hs = 0;
    repeat (gap) @(negedge w_clk);
    in_valid = 1'b1; in_data = W'(d);
    while (!hs && t < 200) begin
      if (in_ready) hs = 1;
      @(negedge w_clk); t++;
    end
    in_valid = 1'b0;
    if (!hs) chk("in_timeout", 1, 0);
    else begin
      chk("in_cnt", int'(o_in_cnt), exp_cnt);
      chk("in_pe_ready", int'(pe_ready), 1);
      chk("in_pe_input", int'(pe_input), d);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (o_busy && t < 200) begin @(negedge w_clk); t++; end
    if (o_busy) chk("idle_timeout", 1, 0);
    @(negedge w_clk);
  endtask

  task automatic pe_reset();
    pe_rst_n = 1'b0; @(negedge w_clk); pe_rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h, h2, seen;
    repeat (3) @(negedge w_clk);
    chk("rst_pe_ready",  int'(pe_ready), 0);
    chk("rst_pe_rw",     int'(pe_rw), 1);
    chk("rst_pe_weight", int'(pe_weight), 0);
    chk("rst_pe_input",  int'(pe_input), 0);
    chk("rst_done",      int'(o_done), 0);
    chk("rst_in_cnt",    int'(o_in_cnt), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_in_ready",  int'(in_ready), 0);
    chk("rst_busy",      int'(o_busy), 0);
    w_rst_n = 1'b1; pe_rst_n = 1'b1;
    @(negedge w_clk);

    // 1: w=3, inputs 1..4 back-to-back -> 30, done at h+7
    send_cfg(3, 4, h); push(3, 4, 4, 30, h + 7);
    for (int i = 1; i <= 4; i++) send_in(i, 0, i);
    wait_idle();

    // 2: same job with a valid every third cycle, fresh PE -> 30, done at h+14
    pe_reset();
    send_cfg(3, 4, h); push(3, 4, 4, 30, h + 14);
    for (int i = 1; i <= 4; i++) send_in(i, 2, i);
    wait_idle();

    // 3: len=0 -> load then drain. The PE output stays 30 and no input is accepted.
    send_cfg(5, 0, h); push(5, 0, 0, 30, h + 3);
    seen = 0;
    in_valid = 1'b1; in_data = 16'd99;
    for (int i = 0; i < 5; i++) begin
      if (in_ready) seen++;
      @(negedge w_clk);
    end
    in_valid = 1'b0;
    chk("t3_in_ready_seen", seen, 0);
    wait_idle();

    // 4: a second cfg waits through job 1 and is accepted the cycle after o_done
    pe_reset();
    send_cfg(3, 4, h); push(3, 4, 4, 30, h + 7);
    fork
      begin
        for (int i = 1; i <= 4; i++) send_in(i, 0, i);
      end
      begin
        repeat (2) @(negedge w_clk);
        chk("t4_cfg_ready_busy", int'(cfg_ready), 0);
        send_cfg(2, 2, h2);
      end
    join
    chk("t4_cfg2_edge", h2, h + 8);
    push(2, 2, 2, 34, h2 + 5);
    send_in(1, 0, 1);
    send_in(1, 0, 2);
    wait_idle();

    // 6: len 13 is clamped to 8. Extra inputs are refused and the count stays at 8.
    pe_reset();
    send_cfg(1, 13, h); push(1, 8, 8, 36, h + 11);
    for (int i = 1; i <= 8; i++) send_in(i, 0, i);
    seen = 0;
    in_valid = 1'b1; in_data = 16'd7;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) seen++;
      @(negedge w_clk);
    end
    in_valid = 1'b0;
    chk("t6_extra_in_ready", seen, 0);
    chk("t6_cnt_hold", int'(o_in_cnt), 8);
    wait_idle();

    // 5: asynchronous reset after 2 of 4 inputs. No done may follow.
    send_cfg(3, 4, h);
    send_in(1, 0, 1);
    send_in(2, 0, 2);
    w_rst_n = 1'b0;
    #1;
    chk("t5_pe_ready",  int'(pe_ready), 0);
    chk("t5_pe_rw",     int'(pe_rw), 1);
    chk("t5_pe_weight", int'(pe_weight), 0);
    chk("t5_pe_input",  int'(pe_input), 0);
    chk("t5_in_cnt",    int'(o_in_cnt), 0);
    chk("t5_busy",      int'(o_busy), 0);
    chk("t5_in_ready",  int'(in_ready), 0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (8) @(negedge w_clk);
    in_valid = 1'b0;
    chk("t5_cfg_ready", int'(cfg_ready), 1);
    chk("t5_busy_after", int'(o_busy), 0);

    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
